// File: rtl/store_rmw_unit.sv
// Store unit: sb/sh read-merge-write a word, sw writes directly; sb/sh take READ_LATENCY+3 cycles, sw 2, misaligned 1.
// Backpressure: req_ready is high only in IDLE, so the requester holds req_valid while busy.
module store_rmw_unit #(
    parameter int READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    input  logic [1:0]  req_store,
    output logic [31:0] mem_addr,
    output logic        mem_rd_en,
    output logic        mem_wr_en,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic        busy
);

    localparam logic [1:0] ST_SB = 2'b01;
    localparam logic [1:0] ST_SH = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_WRITE,
        S_RESP,
        S_ERR
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [1:0]  store_q, store_d;
    logic [31:0] rdata_q, rdata_d;
    logic [2:0]  cnt_q, cnt_d;

    logic        req_misaligned;
    logic        req_is_word;
    logic [4:0]  shamt;
    logic [31:0] lane_mask;
    logic [31:0] merged;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            store_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            store_q <= store_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        req_is_word    = (req_store != ST_SB) && (req_store != ST_SH);
        req_misaligned = ((req_store == ST_SH) && req_addr[0]) ||
                         (req_is_word && (req_addr[1:0] != 2'b00));
    end

    // Byte/half lanes are little-endian within the word; sw bypasses the old data.
    always_comb begin
        shamt     = {addr_q[1:0], 3'b000};
        lane_mask = 32'hFFFF_FFFF;
        if (store_q == ST_SB) begin
            lane_mask = 32'h0000_00FF << shamt;
        end else if (store_q == ST_SH) begin
            lane_mask = 32'h0000_FFFF << shamt;
        end
        merged = (rdata_q & ~lane_mask) | ((data_q << shamt) & lane_mask);
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        store_d = store_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    data_d  = req_data;
                    store_d = req_store;
                    if (req_misaligned) begin
                        state_d = S_ERR;
                    end else if (req_is_word) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_READ: begin
                cnt_d   = 3'(READ_LATENCY);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q - 3'd1;
                // Read data is valid only in the last wait cycle.
                if (cnt_q == 3'd1) begin
                    rdata_d = mem_rdata;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state_q == S_IDLE);
        busy       = (state_q != S_IDLE);
        mem_addr   = {addr_q[31:2], 2'b00};
        mem_rd_en  = (state_q == S_READ);
        mem_wr_en  = (state_q == S_WRITE);
        mem_wdata  = '0;
        resp_valid = (state_q == S_RESP) || (state_q == S_ERR);
        resp_err   = (state_q == S_ERR);
        if (state_q == S_WRITE) begin
            mem_wdata = (store_q == ST_SB || store_q == ST_SH) ? merged : data_q;
        end
    end

endmodule

// File: tb/tb_store_rmw_unit.sv
// Bench for store_rmw_unit: two lanes (READ_LATENCY 1 and 2), each with a memory model,
// a byte-level reference model feeding an expectation queue, and a monitor popping it.
module tb_store_rmw_unit;

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [31:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    localparam int K_RD  = 0;
    localparam int K_WR  = 1;
    localparam int K_RSP = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input int lane_id, input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL lane%0d %s: got %h expected %h", lane_id, name, act, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] widx);
        return (widx * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // Stores described as byte-lane replacement inside a little-endian word.
    function automatic logic [31:0] ref_store(input logic [31:0] old, input logic [31:0] addr,
                                              input logic [31:0] data, input logic [1:0] st);
        logic [7:0] b [4];
        for (int i = 0; i < 4; i++) b[i] = old[8*i +: 8];
        if (st == 2'b01) begin
            b[addr[1:0]] = data[7:0];
        end else if (st == 2'b10) begin
            b[{addr[1], 1'b0}] = data[7:0];
            b[{addr[1], 1'b1}] = data[15:8];
        end else begin
            for (int i = 0; i < 4; i++) b[i] = data[8*i +: 8];
        end
        return {b[3], b[2], b[1], b[0]};
    endfunction

    function automatic bit ref_misaligned(input logic [31:0] addr, input logic [1:0] st);
        if (st == 2'b01) return 1'b0;
        if (st == 2'b10) return addr[0];
        return addr[1:0] != 2'b00;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int L = g + 1;

        logic        rst;
        logic        req_valid;
        logic        req_ready;
        logic [31:0] req_addr;
        logic [31:0] req_data;
        logic [1:0]  req_store;
        logic [31:0] mem_addr;
        logic        mem_rd_en;
        logic        mem_wr_en;
        logic [31:0] mem_wdata;
        logic [31:0] mem_rdata;
        logic        resp_valid;
        logic        resp_err;
        logic        busy;

        int   cyc = 0;
        bit   done = 1'b0;
        exp_t exp_q [$];

        logic [31:0] env_mem [int unsigned];
        logic [31:0] ref_mem [int unsigned];
        logic        vld_sr [L] = '{default: 1'b0};
        logic [31:0] dat_sr [L] = '{default: 32'h0};
        logic [31:0] garb = 32'h0;

        store_rmw_unit #(.READ_LATENCY(L)) dut (
            .clk       (clk),
            .reset     (rst),
            .req_valid (req_valid),
            .req_ready (req_ready),
            .req_addr  (req_addr),
            .req_data  (req_data),
            .req_store (req_store),
            .mem_addr  (mem_addr),
            .mem_rd_en (mem_rd_en),
            .mem_wr_en (mem_wr_en),
            .mem_wdata (mem_wdata),
            .mem_rdata (mem_rdata),
            .resp_valid(resp_valid),
            .resp_err  (resp_err),
            .busy      (busy)
        );

        function automatic logic [31:0] env_rd(input logic [31:0] a);
            if (env_mem.exists(a[31:2])) return env_mem[a[31:2]];
            return init_word({2'b00, a[31:2]});
        endfunction

        function automatic logic [31:0] ref_rd(input logic [31:0] a);
            if (ref_mem.exists(a[31:2])) return ref_mem[a[31:2]];
            return init_word({2'b00, a[31:2]});
        endfunction

        always @(posedge clk) cyc <= cyc + 1;

        // Synchronous memory: data shows up L cycles after the read strobe, noise otherwise.
        always @(posedge clk) begin
            garb      <= $urandom;
            vld_sr[0] <= mem_rd_en && !rst;
            dat_sr[0] <= env_rd(mem_addr);
            for (int k = 1; k < L; k++) begin
                vld_sr[k] <= vld_sr[k-1];
                dat_sr[k] <= dat_sr[k-1];
            end
        end

        always @(posedge clk) begin
            if (mem_wr_en && !rst) env_mem[mem_addr[31:2]] = mem_wdata;
        end

        assign mem_rdata = vld_sr[L-1] ? dat_sr[L-1] : garb;

        task automatic check_ev(input int kind, input logic [31:0] addr, input logic [31:0] data, input logic err);
            exp_t e;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL lane%0d unexpected_event: got kind %0d at cycle %0d expected none", g, kind, cyc);
            end else begin
                e = exp_q.pop_front();
                chk(g, "ev_kind", kind, e.kind);
                chk(g, "ev_cycle", cyc, e.cyc);
                if (e.kind == K_RD)  chk(g, "rd_addr", addr, e.addr);
                if (e.kind == K_WR)  chk(g, "wr_addr", addr, e.addr);
                if (e.kind == K_WR)  chk(g, "wr_data", data, e.data);
                if (e.kind == K_RSP) chk(g, "resp_err", {31'b0, err}, {31'b0, e.err});
            end
        endtask

        always @(negedge clk) begin
            if (!rst) begin
                if (mem_rd_en)  check_ev(K_RD, mem_addr, 32'h0, 1'b0);
                if (mem_wr_en)  check_ev(K_WR, mem_addr, mem_wdata, 1'b0);
                if (resp_valid) check_ev(K_RSP, 32'h0, 32'h0, resp_err);
            end
        end

        task automatic push(input int kind, input logic [31:0] addr, input logic [31:0] data,
                            input logic err, input int c);
            exp_t e;
            e.kind = kind;
            e.addr = {addr[31:2], 2'b00};
            e.data = data;
            e.err  = err;
            e.cyc  = c;
            exp_q.push_back(e);
        endtask

        // Presents a request, returns the cycle index after its accept edge and its latency.
        task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [1:0] st,
                             input bit abort, output int acc, output int lat);
            bit          ok;
            int          n;
            logic [31:0] nw;
            ok = 1'b0;
            n  = 0;
            req_addr  = a;
            req_data  = d;
            req_store = st;
            req_valid = 1'b1;
            while (n < 200) begin
                @(negedge clk);
                n++;
                if (req_ready === 1'b1) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) begin
                total++;
                bad++;
                $display("FAIL lane%0d accept_timeout: got no req_ready in %0d cycles expected acceptance", g, n);
                req_valid = 1'b0;
                acc = -1;
                lat = 0;
                return;
            end
            @(posedge clk);
            #1;
            acc = cyc;
            req_valid = 1'b0;
            nw = ref_store(ref_rd(a), a, d, st);
            if (ref_misaligned(a, st)) begin
                lat = 1;
                push(K_RSP, 32'h0, 32'h0, 1'b1, acc);
            end else if (st == 2'b00 || st == 2'b11) begin
                lat = 2;
                push(K_WR, a, nw, 1'b0, acc);
                push(K_RSP, 32'h0, 32'h0, 1'b0, acc + 1);
                ref_mem[a[31:2]] = nw;
            end else begin
                lat = L + 3;
                push(K_RD, a, 32'h0, 1'b0, acc);
                if (!abort) begin
                    push(K_WR, a, nw, 1'b0, acc + L + 1);
                    push(K_RSP, 32'h0, 32'h0, 1'b0, acc + L + 2);
                    ref_mem[a[31:2]] = nw;
                end
            end
        endtask

        task automatic preload(input logic [31:0] a, input logic [31:0] v);
            env_mem[a[31:2]] = v;
            ref_mem[a[31:2]] = v;
        endtask

        task automatic drain();
            int n;
            n = 0;
            while (exp_q.size() != 0 && n < 100) begin
                @(negedge clk);
                n++;
            end
            @(posedge clk);
            #1;
            chk(g, "drain_pending", 32'(exp_q.size()), 32'h0);
        endtask

        initial begin
            int          a, l, a2, l2, pa, pl;
            bit          held;
            logic [31:0] keep;
            rst       = 1'b1;
            req_valid = 1'b0;
            req_addr  = '0;
            req_data  = '0;
            req_store = '0;
            repeat (2) @(posedge clk);
            #1;
            chk(g, "rst_req_ready", {31'b0, req_ready}, 32'h1);
            chk(g, "rst_busy", {31'b0, busy}, 32'h0);
            chk(g, "rst_rd_en", {31'b0, mem_rd_en}, 32'h0);
            chk(g, "rst_wr_en", {31'b0, mem_wr_en}, 32'h0);
            chk(g, "rst_resp_valid", {31'b0, resp_valid}, 32'h0);
            chk(g, "rst_resp_err", {31'b0, resp_err}, 32'h0);
            chk(g, "rst_mem_addr", mem_addr, 32'h0);
            chk(g, "rst_mem_wdata", mem_wdata, 32'h0);
            @(negedge clk);
            rst = 1'b0;
            @(posedge clk);
            #1;

            if (g == 0) begin
                preload(32'h0200_0004, 32'h1234_5678);
                issue(32'h0200_0005, 32'h0000_00AB, 2'b01, 1'b0, a, l);
                drain();
                chk(g, "sb_word", env_rd(32'h0200_0004), 32'h1234_AB78);
                preload(32'h0000_0100, 32'hDEAD_C0DE);
                issue(32'h0000_0102, 32'hFFFF_BEEF, 2'b10, 1'b0, a, l);
                drain();
                chk(g, "sh_word", env_rd(32'h0000_0100), 32'hBEEF_C0DE);
                preload(32'h0000_0100, 32'hDEAD_C0DE);
                issue(32'h0000_0103, 32'h0000_0011, 2'b01, 1'b0, a, l);
                drain();
                chk(g, "sb_top_word", env_rd(32'h0000_0100), 32'h11AD_C0DE);
                issue(32'h0000_0040, 32'hCAFE_F00D, 2'b00, 1'b0, a, l);
                drain();
                chk(g, "sw_word", env_rd(32'h0000_0040), 32'hCAFE_F00D);
                issue(32'h0000_0043, 32'h0000_1234, 2'b10, 1'b0, a, l);
                drain();
                issue(32'h0000_0042, 32'h5555_AAAA, 2'b11, 1'b0, a, l);
                drain();
                chk(g, "misaligned_no_write", env_rd(32'h0000_0040), 32'hCAFE_F00D);
            end else begin
                preload(32'h0000_0200, 32'h1122_3344);
                issue(32'h0000_0200, 32'h0000_0055, 2'b01, 1'b0, a, l);
                issue(32'h0000_0204, 32'h0BAD_BEEF, 2'b00, 1'b0, a2, l2);
                chk(g, "held_accept_cycle", a2, a + l + 1);
                drain();
                chk(g, "sb_l2_word", env_rd(32'h0000_0200), 32'h1122_3355);
                chk(g, "held_sw_word", env_rd(32'h0000_0204), 32'h0BAD_BEEF);
            end

            held = 1'b0;
            pa   = 0;
            pl   = 0;
            for (int i = 0; i < 60; i++) begin
                if (!held) begin
                    repeat ($urandom_range(1, 3)) @(posedge clk);
                    #1;
                end
                issue(32'h0000_1000 + $urandom_range(0, 31), $urandom, 2'($urandom_range(0, 3)), 1'b0, a, l);
                if (held) chk(g, "rand_held_accept", a, pa + pl + 1);
                pa   = a;
                pl   = l;
                held = ($urandom_range(0, 1) == 1);
            end
            drain();

            // Abandon an sb in its first wait cycle.
            keep = env_rd(32'h0000_1008);
            issue(32'h0000_100A, 32'h0000_00EE, 2'b01, 1'b1, a, l);
            @(posedge clk);
            #2;
            rst = 1'b1;
            #1;
            chk(g, "mid_rst_busy", {31'b0, busy}, 32'h0);
            chk(g, "mid_rst_req_ready", {31'b0, req_ready}, 32'h1);
            chk(g, "mid_rst_wr_en", {31'b0, mem_wr_en}, 32'h0);
            chk(g, "mid_rst_resp_valid", {31'b0, resp_valid}, 32'h0);
            chk(g, "mid_rst_mem_addr", mem_addr, 32'h0);
            @(negedge clk);
            @(negedge clk);
            rst = 1'b0;
            repeat (L + 4) @(posedge clk);
            #1;
            chk(g, "mid_rst_mem_kept", env_rd(32'h0000_1008), keep);
            issue(32'h0000_100B, 32'h0000_0077, 2'b01, 1'b0, a, l);
            drain();
            chk(g, "post_rst_sb_word", env_rd(32'h0000_1008), ref_store(keep, 32'h0000_100B, 32'h77, 2'b01));
            done = 1'b1;
        end
    end

    initial begin
        int n;
        n = 0;
        while (!(lane[0].done && lane[1].done) && n < 20000) begin
            @(posedge clk);
            n++;
        end
        if (!(lane[0].done && lane[1].done)) begin
            total++;
            bad++;
            $display("FAIL global_timeout: got lanes unfinished after %0d cycles expected completion", n);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
